inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register. Owns the PC, issues one-outstanding-request fetches to instruction memory over a req/addr_ok/data_ok handshake, and presents registered `if_pc`/`if_inst`/`if_valid` to IF/ID. Handles downstream stall and branch redirects, including redirects that arrive while a fetch is in flight.

## Interface
- `RESET_PC`, 32'h1C00_0000: first fetch address after reset.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `stall`  in  1  downstream not ready; output registers hold.
- `branch_flag`  in  1  redirect request, one-cycle pulse.
- `branch_target_addr`  in  `InstAddrWidth` (32)  redirect target.
- `inst_req`  out  1  fetch request valid.
- `inst_addr`  out  32  fetch address; stable while `inst_req && !inst_addr_ok`.
- `inst_addr_ok`  in  1  memory accepted request this cycle.
- `inst_data_ok`  in  1  read data valid this cycle.
- `inst_rdata`  in  `InstWidth` (32)  instruction word.
- `if_pc`  out  32  PC of presented instruction.
- `if_inst`  out  32  presented instruction.
- `if_valid`  out  1  `if_pc`/`if_inst` hold a real instruction.
- `if_excp`  out  1  fetch address error (only with `INST_ADEF_EN`; else tied 0).

## Operation
- Reset values: `pc`=RESET_PC, state IDLE, `inst_req`=0, `inst_addr`=RESET_PC, `if_pc`=0, `if_inst`=0, `if_valid`=0, `if_excp`=0, discard=0.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE -> REQ unconditionally one cycle after reset release.
- REQ: `inst_req`=1, `inst_addr`=`pc`. On `inst_addr_ok` -> WAIT.
- WAIT: on `inst_data_ok`: if discard, drop data, clear discard, -> REQ. Else if `!stall`: load outputs (`if_pc`=pc, `if_inst`=rdata, `if_valid`=1), `pc`+=4, -> REQ. Else capture rdata in hold buffer, -> HOLD.
- HOLD: when `!stall`, load outputs from hold buffer, `pc`+=4, -> REQ.
- Output register, when `!stall` and nothing delivered this cycle: `if_valid`<=0 (bubble). When `stall`: all outputs hold.
- `branch_flag`: `pc`<=target; `if_valid`<=0 regardless of `stall`.
  - In REQ without `addr_ok`, or IDLE: next request uses target.
  - In REQ with `addr_ok`, or WAIT without `data_ok`: set discard; -> WAIT.
  - In WAIT with `data_ok` same cycle: data dropped; -> REQ with target.
  - In HOLD: hold buffer dropped; -> REQ.
- `pc`+4 wraps modulo 2^32.
- At most one outstanding request; `inst_req` never asserted in WAIT or HOLD.

## Timing
- Minimum fetch latency: REQ accepted cycle N, `data_ok` earliest N+1, outputs visible N+2.
- Peak throughput with 1-cycle memory: one instruction per 2 cycles.
- `branch_flag` to first target request: next cycle if idle in REQ; otherwise after the in-flight `data_ok`.
- Reset asserted mid-transaction: all state clears immediately; late `data_ok` after reset release in REQ/IDLE is ignored.

## Configuration
- `INST_ADEF_EN` defined: in REQ, if `pc[1:0]`!=0, no request issued; when `!stall` outputs load `if_pc`=pc, `if_inst`=0, `if_valid`=1, `if_excp`=1, then state -> HOLD-like idle until `branch_flag` (pc not advanced).
- Not defined: `inst_addr` = {pc[31:2],2'b00}; `if_excp` constant 0; no check logic.

## Structure
- Shared `define.v`: `InstAddrWidth`, `InstWidth`, RESET_PC constant, fetch state encodings.
- Single module; no sub-module.

## Test plan
- Reset release, memory 1-cycle latency, data 0x0280_0000 -> `inst_addr`=0x1C00_0000, `if_pc`=0x1C00_0000, `if_inst`=0x0280_0000, `if_valid`=1 at cycle 3; next request 0x1C00_0004.
- `stall` high for 3 cycles during `data_ok` -> outputs frozen, hold buffer delivers same instruction once after stall drops, no duplicate/skip.
- `branch_flag` target 0x1C00_0100 while in WAIT -> stale `data_ok` dropped, next `inst_addr`=0x1C00_0100, `if_valid`=0 until target data.
- `branch_flag` coincident with `data_ok` -> data dropped, next request 0x1C00_0100 following cycle.
- `inst_addr_ok` held low 5 cycles -> `inst_addr` stable, `inst_req` high throughout.
- With `INST_ADEF_EN`, branch to 0x1C00_0002 -> no `inst_req`, `if_excp`=1, `if_inst`=0, `if_pc`=0x1C00_0002.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared widths, reset PC and fetch FSM encodings for the instruction-fetch stage.
package inst_fetch_pkg;

    localparam int InstAddrWidth = 32;
    localparam int InstWidth     = 32;

    localparam logic [InstAddrWidth-1:0] RESET_PC = 32'h1C00_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_EXCP
    } fetch_state_e;

    function automatic logic [InstAddrWidth-1:0] pc_next(
        input logic [InstAddrWidth-1:0] pc
    );
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding req/addr_ok/data_ok fetch, stall and redirect.
// Optional INST_ADEF_EN flags misaligned fetch addresses instead of issuing them.
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     branch_flag,
    input  logic [InstAddrWidth-1:0] branch_target_addr,
    output logic                     inst_req,
    output logic [InstAddrWidth-1:0] inst_addr,
    input  logic                     inst_addr_ok,
    input  logic                     inst_data_ok,
    input  logic [InstWidth-1:0]     inst_rdata,
    output logic [InstAddrWidth-1:0] if_pc,
    output logic [InstWidth-1:0]     if_inst,
    output logic                     if_valid,
    output logic                     if_excp
);

    fetch_state_e             state_q, state_d;
    logic [InstAddrWidth-1:0] pc_q, pc_d;
    logic                     discard_q, discard_d;
    logic [InstWidth-1:0]     hold_q, hold_d;
    logic [InstAddrWidth-1:0] if_pc_q, if_pc_d;
    logic [InstWidth-1:0]     if_inst_q, if_inst_d;
    logic                     if_valid_q, if_valid_d;
    logic                     if_excp_q, if_excp_d;
    logic                     deliver;

`ifdef INST_ADEF_EN
    logic misaligned;
    assign misaligned = (pc_q[1:0] != 2'b00);
    assign inst_req   = (state_q == S_REQ) && !misaligned;
    assign inst_addr  = pc_q;
    assign if_excp    = if_excp_q;
`else
    assign inst_req   = (state_q == S_REQ);
    assign inst_addr  = {pc_q[31:2], 2'b00};
    assign if_excp    = 1'b0;
`endif

    assign if_pc    = if_pc_q;
    assign if_inst  = if_inst_q;
    assign if_valid = if_valid_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        discard_d  = discard_q;
        hold_d     = hold_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if_valid_d = if_valid_q;
        if_excp_d  = if_excp_q;
        deliver    = 1'b0;

        if (branch_flag) begin
            pc_d       = branch_target_addr;
            if_valid_d = 1'b0;
            if_excp_d  = 1'b0;
            unique case (state_q)
                S_REQ: begin
                    // An accepted request still owes us a response to swallow.
                    if (inst_req && inst_addr_ok) begin
                        discard_d = 1'b1;
                        state_d   = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        discard_d = 1'b1;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
`ifdef INST_ADEF_EN
                    if (misaligned) begin
                        if (!stall) begin
                            deliver   = 1'b1;
                            if_pc_d   = pc_q;
                            if_inst_d = '0;
                            if_excp_d = 1'b1;
                            state_d   = S_EXCP;
                        end
                    end else if (inst_addr_ok) begin
                        state_d = S_WAIT;
                    end
`else
                    if (inst_addr_ok) begin
                        state_d = S_WAIT;
                    end
`endif
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = S_REQ;
                        end else if (!stall) begin
                            deliver   = 1'b1;
                            if_pc_d   = pc_q;
                            if_inst_d = inst_rdata;
                            pc_d      = pc_next(pc_q);
                            state_d   = S_REQ;
                        end else begin
                            hold_d  = inst_rdata;
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        deliver   = 1'b1;
                        if_pc_d   = pc_q;
                        if_inst_d = hold_q;
                        pc_d      = pc_next(pc_q);
                        state_d   = S_REQ;
                    end
                end
                default: state_d = state_q;
            endcase

            if (deliver) begin
                if_valid_d = 1'b1;
            end else if (!stall) begin
                if_valid_d = 1'b0;
                if_excp_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            discard_q  <= 1'b0;
            hold_q     <= '0;
            if_pc_q    <= '0;
            if_inst_q  <= '0;
            if_valid_q <= 1'b0;
            if_excp_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            discard_q  <= discard_d;
            hold_q     <= hold_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
            if_excp_q  <= if_excp_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a small one-outstanding memory model.
module tb_inst_fetch;

    localparam logic [31:0] RPC = 32'h1C00_0000;
    localparam logic [31:0] TGT = 32'h1C00_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_flag;
    logic [31:0] branch_target_addr;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        if_excp;

    int n_checks = 0;
    int n_fail   = 0;

    logic        ack_en;
    logic        data_en;
    logic        mem_clr;
    logic        pending;
    logic [31:0] pend_addr;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk                (clk),
        .rst                (rst),
        .stall              (stall),
        .branch_flag        (branch_flag),
        .branch_target_addr (branch_target_addr),
        .inst_req           (inst_req),
        .inst_addr          (inst_addr),
        .inst_addr_ok       (inst_addr_ok),
        .inst_data_ok       (inst_data_ok),
        .inst_rdata         (inst_rdata),
        .if_pc              (if_pc),
        .if_inst            (if_inst),
        .if_valid           (if_valid),
        .if_excp            (if_excp)
    );

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a == RPC) ? 32'h0280_0000 : ~a;
    endfunction

    // Memory model: accepts when enabled, answers the following cycle(s).
    assign inst_addr_ok = inst_req & ack_en;
    assign inst_data_ok = pending & data_en;
    assign inst_rdata   = inst_data_ok ? memword(pend_addr) : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (mem_clr) begin
            pending <= 1'b0;
        end else if (inst_req && inst_addr_ok) begin
            pending   <= 1'b1;
            pend_addr <= inst_addr;
        end else if (inst_data_ok) begin
            pending <= 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in REQ presenting RESET_PC.
    task automatic do_reset();
        rst = 1'b0; mem_clr = 1'b1;
        ack_en = 1'b1; data_en = 1'b1;
        stall = 1'b0; branch_flag = 1'b0;
        branch_target_addr = '0;
        step(); step();
        rst = 1'b1; mem_clr = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_clr = 1'b1;
        ack_en = 1'b1; data_en = 1'b1;
        stall = 1'b0; branch_flag = 1'b0;
        branch_target_addr = '0;
        step(); step();
        n_checks++;
        if (inst_req !== 1'b0 || if_valid !== 1'b0 || if_excp !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: req=%b valid=%b excp=%b, want 0 0 0",
                     inst_req, if_valid, if_excp);
        end
        n_checks++;
        if (inst_addr !== RPC || if_pc !== 32'h0 || if_inst !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h pc=%h inst=%h, want %h 0 0",
                     inst_addr, if_pc, if_inst, RPC);
        end
        rst = 1'b1; mem_clr = 1'b0;
        n_checks++;
        if (inst_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: req=%b, want 0", inst_req);
        end
    endtask

    task automatic test_fetch();
        do_reset();
        n_checks++;
        if (inst_req !== 1'b1 || inst_addr !== RPC) begin
            n_fail++;
            $display("FAIL fetch_req0: req=%b addr=%h, want 1 %h",
                     inst_req, inst_addr, RPC);
        end
        step();
        n_checks++;
        if (inst_req !== 1'b0 || if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_wait: req=%b valid=%b, want 0 0",
                     inst_req, if_valid);
        end
        step();
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== RPC || if_inst !== 32'h0280_0000) begin
            n_fail++;
            $display("FAIL fetch_out0: v=%b pc=%h inst=%h, want 1 %h 02800000",
                     if_valid, if_pc, if_inst, RPC);
        end
        n_checks++;
        if (inst_req !== 1'b1 || inst_addr !== 32'h1C00_0004) begin
            n_fail++;
            $display("FAIL fetch_req1: req=%b addr=%h, want 1 1c000004",
                     inst_req, inst_addr);
        end
        step();
        n_checks++;
        if (if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_bubble: valid=%b, want 0", if_valid);
        end
        step();
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h1C00_0004 || if_inst !== 32'hE3FF_FFFB) begin
            n_fail++;
            $display("FAIL fetch_out1: v=%b pc=%h inst=%h, want 1 1c000004 e3fffffb",
                     if_valid, if_pc, if_inst);
        end
    endtask

    task automatic test_stall();
        do_reset();
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (if_valid !== 1'b0 || inst_req !== 1'b0 || if_pc !== 32'h0) begin
                n_fail++;
                $display("FAIL stall_frozen[%0d]: v=%b req=%b pc=%h, want 0 0 0",
                         i, if_valid, inst_req, if_pc);
            end
        end
        stall = 1'b0;
        step();
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== RPC || if_inst !== 32'h0280_0000) begin
            n_fail++;
            $display("FAIL stall_release: v=%b pc=%h inst=%h, want 1 %h 02800000",
                     if_valid, if_pc, if_inst, RPC);
        end
        step();
        n_checks++;
        if (if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_nodup: valid=%b, want 0", if_valid);
        end
        step();
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h1C00_0004) begin
            n_fail++;
            $display("FAIL stall_noskip: v=%b pc=%h, want 1 1c000004",
                     if_valid, if_pc);
        end
    endtask

    task automatic test_branch_wait();
        do_reset();
        data_en = 1'b0;
        step();
        branch_flag = 1'b1; branch_target_addr = TGT;
        step();
        branch_flag = 1'b0;
        n_checks++;
        if (if_valid !== 1'b0 || inst_req !== 1'b0) begin
            n_fail++;
            $display("FAIL bwait_hold: v=%b req=%b, want 0 0", if_valid, inst_req);
        end
        data_en = 1'b1;
        step();
        n_checks++;
        if (if_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== TGT) begin
            n_fail++;
            $display("FAIL bwait_drop: v=%b req=%b addr=%h, want 0 1 %h",
                     if_valid, inst_req, inst_addr, TGT);
        end
        step();
        step();
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== TGT || if_inst !== ~TGT) begin
            n_fail++;
            $display("FAIL bwait_target: v=%b pc=%h inst=%h, want 1 %h %h",
                     if_valid, if_pc, if_inst, TGT, ~TGT);
        end
    endtask

    task automatic test_branch_coincident();
        do_reset();
        step();
        branch_flag = 1'b1; branch_target_addr = TGT;
        step();
        branch_flag = 1'b0;
        n_checks++;
        if (if_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== TGT) begin
            n_fail++;
            $display("FAIL bcoin_req: v=%b req=%b addr=%h, want 0 1 %h",
                     if_valid, inst_req, inst_addr, TGT);
        end
        step();
        step();
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== TGT) begin
            n_fail++;
            $display("FAIL bcoin_out: v=%b pc=%h, want 1 %h", if_valid, if_pc, TGT);
        end
    endtask

    task automatic test_addr_ok_hold();
        do_reset();
        ack_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (inst_req !== 1'b1 || inst_addr !== RPC) begin
                n_fail++;
                $display("FAIL addrok_stable[%0d]: req=%b addr=%h, want 1 %h",
                         i, inst_req, inst_addr, RPC);
            end
        end
        ack_en = 1'b1;
        step();
        step();
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== RPC) begin
            n_fail++;
            $display("FAIL addrok_out: v=%b pc=%h, want 1 %h", if_valid, if_pc, RPC);
        end
    endtask

    task automatic test_branch_req_wrap();
        do_reset();
        ack_en = 1'b0;
        branch_flag = 1'b1; branch_target_addr = 32'hFFFF_FFFC;
        step();
        branch_flag = 1'b0;
        n_checks++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL breq_addr: req=%b addr=%h, want 1 fffffffc",
                     inst_req, inst_addr);
        end
        ack_en = 1'b1;
        step();
        step();
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || inst_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap: v=%b pc=%h next=%h, want 1 fffffffc 0",
                     if_valid, if_pc, inst_addr);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        data_en = 1'b0;
        step();
        rst = 1'b0;
        #1;
        n_checks++;
        if (inst_req !== 1'b0 || if_valid !== 1'b0 || inst_addr !== RPC) begin
            n_fail++;
            $display("FAIL rmid_clear: req=%b v=%b addr=%h, want 0 0 %h",
                     inst_req, if_valid, inst_addr, RPC);
        end
        step();
        rst = 1'b1;
        data_en = 1'b1;
        step();
        n_checks++;
        if (if_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== RPC) begin
            n_fail++;
            $display("FAIL rmid_late: v=%b req=%b addr=%h, want 0 1 %h",
                     if_valid, inst_req, inst_addr, RPC);
        end
        step();
        step();
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== RPC || if_inst !== 32'h0280_0000) begin
            n_fail++;
            $display("FAIL rmid_out: v=%b pc=%h inst=%h, want 1 %h 02800000",
                     if_valid, if_pc, if_inst, RPC);
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        ack_en = 1'b0;
        branch_flag = 1'b1; branch_target_addr = 32'h1C00_0002;
        step();
        branch_flag = 1'b0;
`ifdef INST_ADEF_EN
        n_checks++;
        if (inst_req !== 1'b0) begin
            n_fail++;
            $display("FAIL adef_noreq: req=%b, want 0", inst_req);
        end
        step();
        n_checks++;
        if (if_valid !== 1'b1 || if_excp !== 1'b1 || if_inst !== 32'h0 ||
            if_pc !== 32'h1C00_0002) begin
            n_fail++;
            $display("FAIL adef_out: v=%b excp=%b inst=%h pc=%h, want 1 1 0 1c000002",
                     if_valid, if_excp, if_inst, if_pc);
        end
        step();
        n_checks++;
        if (inst_req !== 1'b0) begin
            n_fail++;
            $display("FAIL adef_park: req=%b, want 0", inst_req);
        end
`else
        n_checks++;
        if (inst_req !== 1'b1 || inst_addr !== 32'h1C00_0000 || if_excp !== 1'b0) begin
            n_fail++;
            $display("FAIL noadef_addr: req=%b addr=%h excp=%b, want 1 1c000000 0",
                     inst_req, inst_addr, if_excp);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_branch_wait();
        test_branch_coincident();
        test_addr_ok_hold();
        test_branch_req_wrap();
        test_reset_mid();
        test_misaligned();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
